cfu_mac_array: RTL and testbench

CFU_MAC_ARRAY -- requirements
Module: cfu_mac_array

---
 rtl/cfu_mac_pkg.sv | 35 +++
 rtl/cfu_mac4_dot.sv | 45 ++++
 rtl/cfu_mac_array.sv | 166 ++++++++++++++++
 tb/tb_cfu_mac_array.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_mac_pkg.sv
// cfu_mac_pkg: opcodes, FSM states and lane arithmetic shared by
// the CFU multiply-accumulate array and its dot-product datapath.
package cfu_mac_pkg;

  localparam int DOT_W  = 20;
  localparam int PROD_W = 18;

  localparam logic [6:0] OP_CLR    = 7'd0;
  localparam logic [6:0] OP_SETOFF = 7'd1;
  localparam logic [6:0] OP_MAC4   = 7'd2;
  localparam logic [6:0] OP_RD     = 7'd3;
  localparam logic [6:0] OP_RDCLR  = 7'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // (int8(a) + off) * int8(b); the 10-bit adjusted operand cannot overflow
  function automatic logic signed [PROD_W-1:0] lane_prod(
    input logic        [7:0] a,
    input logic        [7:0] b,
    input logic signed [8:0] off
  );
    logic signed [9:0]        w_adj;
    logic signed [PROD_W-1:0] w_pa;
    logic signed [PROD_W-1:0] w_pb;
    w_adj = $signed({{2{a[7]}}, a}) + $signed({off[8], off});
    w_pa  = $signed({{8{w_adj[9]}}, w_adj});
    w_pb  = $signed({{10{b[7]}}, b});
    return w_pa * w_pb;
  endfunction

endpackage

// File: rtl/cfu_mac4_dot.sv
// cfu_mac4_dot: four-lane offset-adjusted int8 dot product,
// delayed by MAC_PIPE-1 register stages.
module cfu_mac4_dot
  import cfu_mac_pkg::*;
#(
  parameter int MAC_PIPE = 2
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic [31:0]             i_a,
  input  logic [31:0]             i_b,
  input  logic signed [8:0]       i_off,
  output logic signed [DOT_W-1:0] o_dot
);

  logic signed [DOT_W-1:0]  w_sum;
  logic signed [PROD_W-1:0] w_p;

  always_comb begin
    w_sum = '0;
    w_p   = '0;
    for (int i = 0; i < 4; i++) begin
      w_p   = lane_prod(i_a[8*i +: 8], i_b[8*i +: 8], i_off);
      w_sum = w_sum + $signed({{(DOT_W-PROD_W){w_p[PROD_W-1]}}, w_p});
    end
  end

  if (MAC_PIPE == 1) begin : g_comb
    assign o_dot = w_sum;
  end else begin : g_pipe
    logic signed [DOT_W-1:0] r_pipe [MAC_PIPE-1];

    always_ff @(posedge clk) begin
      if (i_reset) begin
        for (int i = 0; i < MAC_PIPE-1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_sum;
        for (int i = 1; i < MAC_PIPE-1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_dot = r_pipe[MAC_PIPE-2];
  end

endmodule

// File: rtl/cfu_mac_array.sv
// cfu_mac_array: CFU with NUM_ACC accumulators fed by a pipelined
// four-lane int8 MAC, behind a single-outstanding cmd/rsp handshake.
module cfu_mac_array
  import cfu_mac_pkg::*;
#(
  parameter int NUM_ACC  = 4,
  parameter int ACC_W    = 32,
  parameter int MAC_PIPE = 2,
  parameter int SATURATE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int NSLOT = 1 << SEL_W;
  localparam int CNT_W = 2;

  localparam logic signed [32:0] ACC_MAX =
    33'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [32:0] ACC_MIN =
    33'(-(64'sd1 <<< (ACC_W-1)));

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [6:0]               r_op;
  logic [SEL_W-1:0]         r_sel;
  logic signed [8:0]        r_off;
  logic signed [ACC_W-1:0]  r_acc [NSLOT];
  logic signed [ACC_W-1:0]  r_res;

  logic [6:0]               w_cmd_op;
  logic [SEL_W-1:0]         w_cmd_sel;
  logic                     w_accept;
  logic                     w_commit;
  logic [6:0]               w_op;
  logic [SEL_W-1:0]         w_sel;
  logic signed [ACC_W-1:0]  w_acc_cur;
  logic signed [DOT_W-1:0]  w_dot;
  logic signed [32:0]       w_sum33;
  logic signed [ACC_W-1:0]  w_mac_new;
  logic                     w_unused;

  assign w_cmd_op = cmd_payload_function_id[9:3];
  assign w_unused = ^cmd_payload_function_id[2:0];

  if (NUM_ACC > 1) begin : g_sel
    assign w_cmd_sel = cmd_payload_function_id[SEL_W-1:0];
  end else begin : g_sel1
    assign w_cmd_sel = '0;
  end

  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = cmd_ready && cmd_valid;
  assign rsp_valid = (r_state == ST_RESP);

  // commit lands on the edge that enters RESP, never while in it
  assign w_commit =
    (w_accept && ((w_cmd_op != OP_MAC4) || (MAC_PIPE == 1))) ||
    ((r_state == ST_BUSY) && (r_cnt == '0));

  assign w_op  = (r_state == ST_IDLE) ? w_cmd_op  : r_op;
  assign w_sel = (r_state == ST_IDLE) ? w_cmd_sel : r_sel;

  assign w_acc_cur = r_acc[w_sel];

  cfu_mac4_dot #(
    .MAC_PIPE (MAC_PIPE)
  ) u_dot (
    .clk     (clk),
    .i_reset (reset),
    .i_a     (cmd_payload_inputs_0),
    .i_b     (cmd_payload_inputs_1),
    .i_off   (r_off),
    .o_dot   (w_dot)
  );

  assign w_sum33 =
    $signed({{(33-ACC_W){w_acc_cur[ACC_W-1]}}, w_acc_cur}) +
    $signed({{(33-DOT_W){w_dot[DOT_W-1]}}, w_dot});

  always_comb begin
    w_mac_new = w_sum33[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (w_sum33 > ACC_MAX) begin
        w_mac_new = ACC_MAX[ACC_W-1:0];
      end else if (w_sum33 < ACC_MIN) begin
        w_mac_new = ACC_MIN[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sel   <= '0;
      r_off   <= '0;
      r_res   <= '0;
      for (int i = 0; i < NSLOT; i++) r_acc[i] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op  <= w_cmd_op;
            r_sel <= w_cmd_sel;
            if ((w_cmd_op == OP_MAC4) && (MAC_PIPE > 1)) begin
              r_state <= ST_BUSY;
              r_cnt   <= CNT_W'(MAC_PIPE - 2);
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) r_state <= ST_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
            r_res   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_commit) begin
        unique case (1'b1)
          (w_op == OP_CLR): begin
            r_acc[w_sel] <= '0;
            r_res        <= '0;
          end
          (w_op == OP_SETOFF): begin
            r_off <= $signed(cmd_payload_inputs_0[8:0]);
            r_res <= '0;
          end
          (w_op == OP_MAC4): begin
            r_acc[w_sel] <= w_mac_new;
            r_res        <= w_mac_new;
          end
          (w_op == OP_RD): begin
            r_res <= w_acc_cur;
          end
          (w_op == OP_RDCLR): begin
            r_res        <= w_acc_cur;
            r_acc[w_sel] <= '0;
          end
          default: r_res <= '0;
        endcase
      end
    end
  end

  assign rsp_payload_outputs_0 = 32'(r_res);

endmodule

// File: tb/tb_cfu_mac_array.sv
// tb_cfu_mac_array: three differently parameterised arrays driven in
// lockstep and checked every cycle against a behavioural model.
module tb_cfu_mac_array;

  localparam logic [6:0] C_CLR    = 7'd0;
  localparam logic [6:0] C_SETOFF = 7'd1;
  localparam logic [6:0] C_MAC4   = 7'd2;
  localparam logic [6:0] C_RD     = 7'd3;
  localparam logic [6:0] C_RDCLR  = 7'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        rsp_ready;
  logic [9:0]  fid;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [2:0]  cr;
  logic [2:0]  rv;
  logic [31:0] rd [3];

  int n_chk  = 0;
  int n_pass = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  cfu_mac_array #(.NUM_ACC(4), .ACC_W(32), .MAC_PIPE(2), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr[0]),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0),
    .cmd_payload_inputs_1(in1), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rd[0]));

  cfu_mac_array #(.NUM_ACC(2), .ACC_W(16), .MAC_PIPE(3), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr[1]),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0),
    .cmd_payload_inputs_1(in1), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rd[1]));

  cfu_mac_array #(.NUM_ACC(1), .ACC_W(16), .MAC_PIPE(1), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr[2]),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0),
    .cmd_payload_inputs_1(in1), .rsp_valid(rv[2]), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rd[2]));

  function automatic int pipe_of(int k);
    case (k) 0: return 2; 1: return 3; default: return 1; endcase
  endfunction
  function automatic int aw_of(int k);
    return (k == 0) ? 32 : 16;
  endfunction
  function automatic int sat_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int nacc_of(int k);
    case (k) 0: return 4; 1: return 2; default: return 1; endcase
  endfunction

  task automatic chk(string name, longint got, longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  name, got, got, want, want);
  endtask

  // behavioural model: one outstanding command per array, result due
  // a fixed number of cycles after acceptance
  longint      m_acc  [3][8];
  longint      m_data [3];
  longint      m_off  [3];
  bit          m_busy [3];
  bit          m_valid[3];
  longint      m_due  [3];
  int          m_op   [3];
  int          m_sel  [3];
  logic [31:0] m_a    [3];
  logic [31:0] m_b    [3];
  longint      pc = 0;

  function automatic longint s8(logic [7:0] x);
    return (x > 8'd127) ? longint'(x) - 256 : longint'(x);
  endfunction

  function automatic longint fit(int k, longint v);
    longint lim;
    lim = 64'sd1 <<< (aw_of(k) - 1);
    if (sat_of(k) != 0) begin
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
    end
    v = v % (2 * lim);
    if (v >= lim) v -= 2 * lim;
    if (v < -lim) v += 2 * lim;
    return v;
  endfunction

  task automatic apply(int k);
    longint r;
    longint dot;
    int s;
    r = 0;
    dot = 0;
    s = m_sel[k];
    case (m_op[k])
      0: m_acc[k][s] = 0;
      1: m_off[k] = m_a[k][8] ? longint'(m_a[k][8:0]) - 512
                              : longint'(m_a[k][8:0]);
      2: begin
        for (int i = 0; i < 4; i++)
          dot += (s8(m_a[k][8*i +: 8]) + m_off[k]) * s8(m_b[k][8*i +: 8]);
        m_acc[k][s] = fit(k, m_acc[k][s] + dot);
        r = m_acc[k][s];
      end
      3: r = m_acc[k][s];
      4: begin
        r = m_acc[k][s];
        m_acc[k][s] = 0;
      end
      default: r = 0;
    endcase
    m_data[k] = r;
  endtask

  always @(posedge clk) begin
    pc++;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_busy[k]  = 1'b0;
        m_valid[k] = 1'b0;
        m_data[k]  = 0;
        m_off[k]   = 0;
        for (int c = 0; c < 8; c++) m_acc[k][c] = 0;
      end else begin
        if (m_valid[k]) begin
          if (rsp_ready) begin
            m_valid[k] = 1'b0;
            m_busy[k]  = 1'b0;
            m_data[k]  = 0;
          end
        end else if (!m_busy[k] && cmd_valid) begin
          m_busy[k] = 1'b1;
          m_op[k]   = int'(fid[9:3]);
          m_sel[k]  = int'(fid[2:0]) % nacc_of(k);
          m_a[k]    = in0;
          m_b[k]    = in1;
          m_due[k]  = pc + ((m_op[k] == 2) ? pipe_of(k) : 1) - 1;
        end
        if (m_busy[k] && !m_valid[k] && pc == m_due[k]) begin
          apply(k);
          m_valid[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.rsp_valid", k), longint'(rv[k]),
            longint'(m_valid[k]));
        chk($sformatf("u%0d.rsp_data", k), longint'(rd[k]),
            longint'(m_data[k][31:0]));
        chk($sformatf("u%0d.cmd_ready", k), longint'(cr[k]),
            longint'(!reset && !m_busy[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_res [3];
  int          q_lat [3];

  task automatic do_cmd(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    bit got [3];
    bit done;
    int n;
    got  = '{1'b0, 1'b0, 1'b0};
    done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q_res[k] = 32'hDEAD_BEEF;
      q_lat[k] = -1;
    end
    cmd_valid = 1'b1;
    fid       = {op, f3};
    in0       = a;
    in1       = b;
    rsp_ready = (hold == 0);
    cyc();
    cmd_valid = 1'b0;
    fid       = 10'($urandom);
    in0       = $urandom;
    in1       = $urandom;
    for (n = 1; n <= 40 && !done; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (rv[k] && !got[k]) begin
          got[k]   = 1'b1;
          q_res[k] = rd[k];
          q_lat[k] = n;
        end
      end
      if (got[0] && got[1] && got[2] && rv == 3'b000) begin
        done = 1'b1;
      end else begin
        if (hold > 0 && n < hold + 3) begin
          rsp_ready = 1'b0;
          cmd_valid = poke;
          fid       = 10'($urandom);
        end else begin
          rsp_ready = 1'b1;
          cmd_valid = 1'b0;
        end
        cyc();
      end
    end
    if (!done) chk("cmd_timeout", 0, 1);
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    fid       = '0;
    in0       = '0;
    in1       = '0;
    cyc();
    run_chk = 1'b1;
    cyc();
    chk("reset.cmd_ready", longint'(cr), 0);
    chk("reset.rsp_valid", longint'(rv), 0);
    chk("reset.rsp_data0", longint'(rd[0]), 0);
    reset = 1'b0;
    #1;
    chk("idle.cmd_ready", longint'(cr), 7);

    do_cmd(C_MAC4, 3'd0, 32'h0102_0304, 32'h0101_0101, 0, 1'b0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("mac_basic.u%0d", k), longint'(q_res[k]), 10);
    chk("mac_lat.u0", q_lat[0], 2);
    chk("mac_lat.u1", q_lat[1], 3);
    chk("mac_lat.u2", q_lat[2], 1);
    do_cmd(C_MAC4, 3'd0, 32'h0102_0304, 32'h0101_0101, 0, 1'b0);
    chk("mac_repeat.u0", longint'(q_res[0]), 20);

    do_cmd(C_CLR, 3'd0, 32'h0, 32'h0, 0, 1'b0);
    do_cmd(C_SETOFF, 3'd0, 32'h0000_0080, 32'h0, 0, 1'b0);
    chk("setoff.rsp", longint'(q_res[0]), 0);
    chk("setoff.lat", q_lat[0], 1);
    do_cmd(C_MAC4, 3'd0, 32'h8080_8080, 32'hFFFF_FFFF, 0, 1'b0);
    chk("off128.u0", longint'(q_res[0]), 0);
    do_cmd(C_SETOFF, 3'd0, 32'h0, 32'h0, 0, 1'b0);
    do_cmd(C_MAC4, 3'd0, 32'h8080_8080, 32'hFFFF_FFFF, 0, 1'b0);
    chk("off0.u0", longint'(q_res[0]), 512);
    chk("off0.u1", longint'(q_res[1]), 512);

    do_cmd(C_RD, 3'd0, 32'h0, 32'h0, 5, 1'b1);
    chk("backpressure.u0", longint'(q_res[0]), 512);
    chk("backpressure.u2", longint'(q_res[2]), 512);

    do_cmd(C_CLR, 3'd0, 32'h0, 32'h0, 0, 1'b0);
    do_cmd(C_MAC4, 3'd0, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 0, 1'b0);
    chk("sat.u0_wide", longint'(q_res[0]), 64516);
    chk("sat.u1_clamp", longint'(q_res[1]), 32767);
    chk("sat.u2_wrap", longint'(q_res[2]), 32'hFFFF_FC04);

    do_cmd(C_CLR, 3'd0, 32'h0, 32'h0, 0, 1'b0);
    do_cmd(C_MAC4, 3'd1, 32'h0102_0304, 32'h0101_0101, 0, 1'b0);
    chk("iso.mac1.u0", longint'(q_res[0]), 10);
    do_cmd(C_RD, 3'd0, 32'h0, 32'h0, 0, 1'b0);
    chk("iso.rd0.u0", longint'(q_res[0]), 0);
    chk("iso.rd0.u1", longint'(q_res[1]), 0);
    do_cmd(C_RDCLR, 3'd1, 32'h0, 32'h0, 0, 1'b0);
    chk("iso.rdclr1.u0", longint'(q_res[0]), 10);
    chk("iso.rdclr1.u1", longint'(q_res[1]), 10);
    do_cmd(C_RD, 3'd1, 32'h0, 32'h0, 0, 1'b0);
    chk("iso.rd1.u0", longint'(q_res[0]), 0);
    do_cmd(7'd9, 3'd1, 32'h0, 32'h0, 0, 1'b0);
    chk("bad_op.u0", longint'(q_res[0]), 0);

    for (int t = 0; t < 150; t++) begin
      int          pick;
      logic [6:0]  op;
      logic [31:0] a;
      pick = $urandom_range(0, 6);
      op   = (pick < 5) ? 7'(pick) : 7'($urandom_range(5, 127));
      a    = $urandom;
      if (op == C_SETOFF && $urandom_range(0, 1) == 1)
        a = 32'($urandom_range(0, 511));
      do_cmd(op, 3'($urandom), a, $urandom,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
             1'($urandom));
    end

    cmd_valid = 1'b1;
    fid       = {C_MAC4, 3'd0};
    in0       = 32'h0102_0304;
    in1       = 32'h0101_0101;
    rsp_ready = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    cnt   = 0;
    repeat (6) begin
      if (rv[0] || rv[1]) cnt++;
      cyc();
    end
    chk("midreset.no_rsp", cnt, 0);
    for (int s = 0; s < 4; s++) begin
      do_cmd(C_RD, 3'(s), 32'h0, 32'h0, 0, 1'b0);
      chk($sformatf("midreset.rd%0d.u0", s), longint'(q_res[0]), 0);
      chk($sformatf("midreset.rd%0d.u1", s), longint'(q_res[1]), 0);
    end

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
